fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and flag controller for the FIFO built around the register file. Each accepted write stores one full word at the write pointer. Each stored word is then consumed as two half-word reads: upper half first, then lower half. The block drives the register file's write enable, write address, read address and half-select, and tells the producer and consumer when the FIFO is full or empty.

## Interface
- ADDR_WIDTH, default 2: pointer width; capacity is 2**ADDR_WIDTH words, which is 2**(ADDR_WIDTH+1) halves.

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  producer write request.
- rd  input  1  consumer read request, one half-word per accepted read.
- w_en  output  1  register-file write strobe; combinational, equal to wr & ~full.
- w_addr  output  ADDR_WIDTH  write pointer; registered.
- r_addr  output  ADDR_WIDTH  read pointer; registered.
- same_read  output  1  half-select to the register file; 0 selects the upper half, 1 the lower half; registered.
- empty  output  1  no unread halves remain; registered.
- full  output  1  all 2**ADDR_WIDTH entries hold at least one unread half; registered.

## Operation
- State:
  - w_ptr, r_ptr (ADDR_WIDTH bits each).
  - half bit (drives same_read).
  - cnt, in words, ADDR_WIDTH+1 bits. A word stays counted until its lower half has been read.
- Acceptance:
  - Write is accepted when wr & ~full.
  - Read is accepted when rd & ~empty.
  - Requests that are not accepted are dropped silently. State does not change and there is no error flag.
- Accepted write: w_ptr <= w_ptr+1, wrapping modulo 2**ADDR_WIDTH.
- Accepted read with half=0: half <= 1. r_ptr and cnt are unchanged.
- Accepted read with half=1: half <= 0, r_ptr <= r_ptr+1 (wrapping), and the entry is released.
- cnt update:
  - Increments on an accepted write.
  - Decrements on a releasing read.
  - Is unchanged when both happen in the same cycle, or when neither does.
- Flags:
  - full = (cnt == 2**ADDR_WIDTH).
  - empty = (cnt == 0).
  - Both are registered, recomputed from next-state cnt.
- Simultaneous wr and rd:
  - While full: the write is rejected, even if the read releases an entry; the read is accepted.
  - While empty: the read is rejected; the write is accepted.
  - Otherwise both are accepted.
- Pointers wrap freely; full and empty are decided only by cnt, never by pointer compare.

## Timing
- Reset values: w_ptr=0, r_ptr=0, same_read=0, cnt=0, empty=1, full=0. w_en=0 while wr=0.
- Reset wins over wr/rd in the same cycle. Reset mid-stream discards all contents and the pending half.
- Write latency:
  - w_en and w_addr are valid in the request cycle; the register file captures the word on that edge.
  - empty falls on the following edge.
  - Read data for that word is visible one cycle after the write (async read, fall-through).
- Read data tracks r_addr and same_read combinationally, so the consumer samples it in the same cycle it asserts rd.
- full rises on the edge that accepts the 2**ADDR_WIDTH-th unreleased write. It falls on the edge of the next releasing read.

## Configuration
- FIFO_CTRL_OCCUPANCY_EN defined:
  - Adds output occupancy, width ADDR_WIDTH+2.
  - Value = 2*cnt - half, i.e. the number of unread halves.
  - Combinational from registered state; reset value 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then idle: empty=1, full=0, w_addr=0, r_addr=0, same_read=0, w_en=0; with the macro, occupancy=0.
- ADDR_WIDTH=2, four writes on consecutive cycles: w_addr steps 0,1,2,3; full=1 after the 4th edge. A 5th wr gives w_en=0 and w_addr stays 0.
- Starting full, eight consecutive rd:
  - same_read toggles 0,1 per read; r_addr steps 0,0,1,1,2,2,3,3.
  - full falls after the 2nd read; empty rises after the 8th read.
  - A 9th rd is ignored.
- Simultaneous wr and rd with cnt=1 and half=1: cnt stays 1, r_addr+1, w_addr+1, same_read returns to 0.
- Simultaneous wr and rd while full with half=1: write rejected (w_en=0), entry released, full=0 next cycle. Also simultaneous wr and rd while empty: only the write takes effect.
- Reset asserted after two writes and one read: the next cycle shows all reset values. A subsequent write lands at w_addr=0.

Source files
------------

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl
//  Description : Pointer and flag controller for a register-file FIFO. Each
//                accepted write stores one full word at the write pointer.
//                Each stored word is read back as two half-words, upper half
//                first. A word stays counted until its lower half is read.
//  Ports       : clk       - single clock, rising edge
//                reset     - synchronous, active-high reset
//                wr        - producer write request
//                rd        - consumer read request (one half-word per read)
//                w_en      - register-file write strobe (wr & ~full)
//                w_addr    - write pointer (registered)
//                r_addr    - read pointer (registered)
//                same_read - half select, 0 = upper half, 1 = lower half
//                empty     - no unread halves remain (registered)
//                full      - every entry holds an unread half (registered)
//                occupancy - unread half count, only with
//                            FIFO_CTRL_OCCUPANCY_EN defined
//  Options     : FIFO_CTRL_OCCUPANCY_EN adds the occupancy output
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  same_read,
  output logic                  empty,
`ifdef FIFO_CTRL_OCCUPANCY_EN
  output logic [ADDR_WIDTH+1:0] occupancy,
`endif
  output logic                  full
);

  // Word count at which every entry is occupied.
  localparam logic [ADDR_WIDTH:0] c_cnt_full = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic                  half_q,  half_d;
  logic [ADDR_WIDTH:0]   cnt_q,   cnt_d;
  logic                  empty_q, empty_d;
  logic                  full_q,  full_d;

  logic w_wr_acc;
  logic w_rd_acc;
  logic w_release;

  always_comb begin
    w_wr_acc  = wr & ~full_q;
    w_rd_acc  = rd & ~empty_q;
    // Only the lower-half read frees the entry.
    w_release = w_rd_acc & half_q;

    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    half_d  = half_q;
    cnt_d   = cnt_q;

    if (w_wr_acc) begin
      w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
    end

    if (w_rd_acc) begin
      half_d = ~half_q;
      if (half_q) begin
        r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
      end
    end

    // Write and release in the same cycle cancel out.
    if (w_wr_acc && !w_release) begin
      cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
    end else if (!w_wr_acc && w_release) begin
      cnt_d = cnt_q - (ADDR_WIDTH+1)'(1);
    end

    // Flags are derived from the next count so they are ready as registers.
    full_d  = (cnt_d == c_cnt_full);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign w_en      = w_wr_acc;
  assign w_addr    = w_ptr_q;
  assign r_addr    = r_ptr_q;
  assign same_read = half_q;
  assign empty     = empty_q;
  assign full      = full_q;

`ifdef FIFO_CTRL_OCCUPANCY_EN
  // Unread halves: two per counted word, minus one if the upper half is gone.
  assign occupancy = {1'b0, cnt_q, 1'b0} - (ADDR_WIDTH+2)'(half_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ctrl
//  Description : Directed self-checking bench for fifo_ctrl (ADDR_WIDTH = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  localparam int ADDR_WIDTH = 2;

  logic                  clk;
  logic                  reset;
  logic                  wr;
  logic                  rd;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  same_read;
  logic                  empty;
  logic                  full;
`ifdef FIFO_CTRL_OCCUPANCY_EN
  logic [ADDR_WIDTH+1:0] occupancy;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fifo_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .rd        (rd),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .r_addr    (r_addr),
    .same_read (same_read),
    .empty     (empty),
`ifdef FIFO_CTRL_OCCUPANCY_EN
    .occupancy (occupancy),
`endif
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int wa, input int ra, input int sr,
                             input int em, input int fu, input int occ);
    check({tag, ".w_addr"},    32'(w_addr),    32'(wa));
    check({tag, ".r_addr"},    32'(r_addr),    32'(ra));
    check({tag, ".same_read"}, 32'(same_read), 32'(sr));
    check({tag, ".empty"},     32'(empty),     32'(em));
    check({tag, ".full"},      32'(full),      32'(fu));
`ifdef FIFO_CTRL_OCCUPANCY_EN
    check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
`else
    if (occ < 0) $display("unexpected occupancy value %0d", occ);
`endif
  endtask

  initial begin
    reset = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_state("reset", 0, 0, 0, 1, 0, 0);
    check("reset.w_en", 32'(w_en), 32'd0);

    // Fill with four consecutive writes.
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1;
      #1;
      check($sformatf("fill%0d.w_en", i),   32'(w_en),   32'd1);
      check($sformatf("fill%0d.w_addr", i), 32'(w_addr), 32'(i));
      tick();
    end
    check_state("filled", 0, 0, 0, 0, 1, 8);

    // Fifth write is dropped.
    #1;
    check("wr_full.w_en", 32'(w_en), 32'd0);
    tick();
    check_state("wr_full", 0, 0, 0, 0, 1, 8);

    // Drain with eight half-word reads.
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1;
      #1;
      check($sformatf("rd%0d.same_read", i), 32'(same_read), 32'(i % 2));
      check($sformatf("rd%0d.r_addr", i),    32'(r_addr),    32'(i / 2));
      tick();
      check($sformatf("rd%0d.full", i),  32'(full),  32'(i == 0));
      check($sformatf("rd%0d.empty", i), 32'(empty), 32'(i == 7));
    end
    // Ninth read is ignored; r_addr has wrapped back to 0.
    tick();
    check_state("rd_empty", 0, 0, 0, 1, 0, 0);

    // Simultaneous wr and rd while empty: only the write takes effect.
    wr = 1'b1;
    rd = 1'b1;
    #1;
    check("both_empty.w_en", 32'(w_en), 32'd1);
    tick();
    check_state("both_empty", 1, 0, 0, 0, 0, 2);

    // Read the upper half so half=1 with cnt=1.
    wr = 1'b0;
    tick();
    check_state("half1", 1, 0, 1, 0, 0, 1);

    // Simultaneous wr and rd with cnt=1, half=1: cnt stays 1.
    wr = 1'b1;
    #1;
    check("both_mid.w_en", 32'(w_en), 32'd1);
    tick();
    check_state("both_mid", 2, 1, 0, 0, 0, 2);

    // Three writes bring cnt to 4 (full).
    rd = 1'b0;
    tick();
    tick();
    tick();
    check_state("refill", 1, 1, 0, 0, 1, 8);

    // Upper-half read, then simultaneous wr/rd while full with half=1.
    wr = 1'b0;
    rd = 1'b1;
    tick();
    check_state("full_half1", 1, 1, 1, 0, 1, 7);
    wr = 1'b1;
    #1;
    check("both_full.w_en", 32'(w_en), 32'd0);
    tick();
    check_state("both_full", 1, 2, 0, 0, 0, 6);

    // Reset mid-stream: two writes and one read, then reset with requests high.
    wr = 1'b0;
    rd = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr = 1'b1;
    tick();
    tick();
    wr = 1'b0;
    rd = 1'b1;
    tick();
    check_state("pre_reset", 2, 0, 1, 0, 0, 3);
    wr = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    #1;
    check_state("mid_reset", 0, 0, 0, 1, 0, 0);
    check("mid_reset.w_en", 32'(w_en), 32'd0);

    wr = 1'b1;
    #1;
    check("post_reset.w_en",   32'(w_en),   32'd1);
    check("post_reset.w_addr", 32'(w_addr), 32'd0);
    tick();
    wr = 1'b0;
    check_state("post_reset", 1, 0, 0, 0, 0, 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
